// File: rtl/game_pkg.sv
// game_pkg: shared state encoding, geometry defaults, screen bounds and colours
// for the game sequencer and its collision helper.
package game_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_HIT  = 2'd2,
        S_OVER = 2'd3
    } game_state_t;

    localparam int PLAYER_HALF_DEF = 30;
    localparam int OBS_HALF_W_DEF  = 40;
    localparam int OBS_HALF_H_DEF  = 10;

    localparam int X_MIN = 150;
    localparam int X_MAX = 800;
    localparam int Y_MIN = 34;
    localparam int Y_MAX = 514;

    localparam logic [11:0] RED    = 12'hF00;
    localparam logic [11:0] PURPLE = 12'hF0F;

    localparam logic [3:0] SPEED_INIT = 4'd2;

endpackage

// File: rtl/game_sequencer_box_overlap.sv
// box_overlap: combinational inclusive overlap test between two axis-aligned
// boxes given their centres and the summed half-extents per axis.
module box_overlap #(
    parameter int HALF_X = 70,
    parameter int HALF_Y = 40
) (
    input  logic [9:0] i_xa,
    input  logic [9:0] i_ya,
    input  logic [9:0] i_xb,
    input  logic [9:0] i_yb,
    output logic       o_hit
);

    logic [10:0] w_dx;
    logic [10:0] w_dy;

    always_comb begin
        w_dx  = (i_xa >= i_xb) ? ({1'b0, i_xa} - {1'b0, i_xb}) : ({1'b0, i_xb} - {1'b0, i_xa});
        w_dy  = (i_ya >= i_yb) ? ({1'b0, i_ya} - {1'b0, i_yb}) : ({1'b0, i_yb} - {1'b0, i_ya});
        o_hit = (w_dx <= 11'(HALF_X)) && (w_dy <= 11'(HALF_Y));
    end

endmodule

// File: rtl/game_sequencer.sv
// game_sequencer: IDLE/PLAY/HIT/OVER controller with collision, lives, score, speed.
// Optional build macro: GAME_SEQ_LEVELUP_EN (speed steps up every LEVEL_PTS points).
module game_sequencer
    import game_pkg::*;
#(
    parameter int LIVES       = 3,
    parameter int HIT_TICKS   = 30,
    parameter int SCORE_TICKS = 60,
    parameter int PLAYER_HALF = PLAYER_HALF_DEF,
    parameter int OBS_HALF_W  = OBS_HALF_W_DEF,
    parameter int OBS_HALF_H  = OBS_HALF_H_DEF,
    parameter int LEVEL_PTS   = 8,
    parameter int MAX_SPEED   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       start,
    input  logic [9:0] xpos,
    input  logic [9:0] ypos,
    input  logic [9:0] xpos_obs,
    input  logic [9:0] ypos_obs,
    input  logic [9:0] xpos_vobs,
    input  logic [9:0] ypos_vobs,
    output logic [1:0] state,
    output logic       move_en,
    output logic [3:0] speed,
    output logic [1:0] lives,
    output logic [9:0] score,
    output logic       hit_flash,
    output logic       game_over
);

    localparam int HCW = (HIT_TICKS > 1) ? $clog2(HIT_TICKS) : 1;
    localparam int SCW = (SCORE_TICKS > 1) ? $clog2(SCORE_TICKS) : 1;
    localparam logic [HCW-1:0] HIT_LOAD   = HCW'(HIT_TICKS - 1);
    localparam logic [SCW-1:0] SCORE_LAST = SCW'(SCORE_TICKS - 1);
    localparam logic [1:0]     LIVES_INIT = 2'(LIVES);

    game_state_t    r_state, w_state_nx;
    logic [1:0]     r_lives, w_lives_nx;
    logic [9:0]     r_score, w_score_nx;
    logic [3:0]     r_speed, w_speed_nx;
    logic [SCW-1:0] r_score_cnt, w_score_cnt_nx;
    logic [HCW-1:0] r_hit_cnt, w_hit_cnt_nx;
    logic           r_coll, r_start_q, r_move_en, r_hit_flash, r_game_over;
    logic           w_hit0, w_hit1, w_start_rise;

    box_overlap #(.HALF_X(PLAYER_HALF + OBS_HALF_W), .HALF_Y(PLAYER_HALF + OBS_HALF_H)) u_ovl0 (
        .i_xa(xpos), .i_ya(ypos), .i_xb(xpos_obs), .i_yb(ypos_obs), .o_hit(w_hit0)
    );

    box_overlap #(.HALF_X(PLAYER_HALF + OBS_HALF_W), .HALF_Y(PLAYER_HALF + OBS_HALF_H)) u_ovl1 (
        .i_xa(xpos), .i_ya(ypos), .i_xb(xpos_vobs), .i_yb(ypos_vobs), .o_hit(w_hit1)
    );

    assign w_start_rise = start & ~r_start_q;

`ifndef GAME_SEQ_LEVELUP_EN
    logic w_unused_cfg;
    assign w_unused_cfg = (LEVEL_PTS > 0) ^ (MAX_SPEED > 0);
`endif

    always_comb begin
        w_state_nx     = r_state;
        w_lives_nx     = r_lives;
        w_score_nx     = r_score;
        w_speed_nx     = r_speed;
        w_score_cnt_nx = r_score_cnt;
        w_hit_cnt_nx   = r_hit_cnt;
        case (r_state)
            S_IDLE: begin
                w_lives_nx     = LIVES_INIT;
                w_score_nx     = '0;
                w_speed_nx     = SPEED_INIT;
                w_score_cnt_nx = '0;
                w_hit_cnt_nx   = '0;
                if (w_start_rise) w_state_nx = S_PLAY;
            end
            S_PLAY: begin
                if (tick && r_coll) begin
                    w_lives_nx = r_lives - 2'd1;
                    if (w_lives_nx == 2'd0) begin
                        w_state_nx = S_OVER;
                    end else begin
                        w_state_nx   = S_HIT;
                        w_hit_cnt_nx = HIT_LOAD;
                    end
                end else if (tick) begin
                    // The rollover tick itself awards the point; score_cnt keeps cycling once score saturates.
                    if (r_score_cnt == SCORE_LAST) begin
                        w_score_cnt_nx = '0;
                        if (r_score != '1) begin
                            w_score_nx = r_score + 10'd1;
`ifdef GAME_SEQ_LEVELUP_EN
                            if ((w_score_nx % 10'(LEVEL_PTS)) == '0 && r_speed < 4'(MAX_SPEED))
                                w_speed_nx = r_speed + 4'd1;
`endif
                        end
                    end else begin
                        w_score_cnt_nx = r_score_cnt + 1'b1;
                    end
                end
            end
            S_HIT: begin
                if (tick) begin
                    if (r_hit_cnt == '0) w_state_nx = S_PLAY;
                    else                 w_hit_cnt_nx = r_hit_cnt - 1'b1;
                end
            end
            S_OVER: begin
                if (w_start_rise) begin
                    w_state_nx     = S_PLAY;
                    w_lives_nx     = LIVES_INIT;
                    w_score_nx     = '0;
                    w_speed_nx     = SPEED_INIT;
                    w_score_cnt_nx = '0;
                    w_hit_cnt_nx   = '0;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_lives     <= LIVES_INIT;
            r_score     <= '0;
            r_speed     <= SPEED_INIT;
            r_score_cnt <= '0;
            r_hit_cnt   <= '0;
            r_coll      <= 1'b0;
            r_start_q   <= 1'b0;
            r_move_en   <= 1'b0;
            r_hit_flash <= 1'b0;
            r_game_over <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_lives     <= w_lives_nx;
            r_score     <= w_score_nx;
            r_speed     <= w_speed_nx;
            r_score_cnt <= w_score_cnt_nx;
            r_hit_cnt   <= w_hit_cnt_nx;
            r_coll      <= w_hit0 | w_hit1;
            r_start_q   <= start;
            r_move_en   <= (w_state_nx == S_PLAY);
            r_hit_flash <= (w_state_nx == S_HIT);
            r_game_over <= (w_state_nx == S_OVER);
        end
    end

    assign state     = r_state;
    assign move_en   = r_move_en;
    assign speed     = r_speed;
    assign lives     = r_lives;
    assign score     = r_score;
    assign hit_flash = r_hit_flash;
    assign game_over = r_game_over;

endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: directed and randomized checks of game_sequencer against a
// rule-level reference model (mode, lives, score from total clean ticks).
module tb_game_sequencer;

    localparam int LIVES       = 3;
    localparam int HIT_TICKS   = 30;
    localparam int SCORE_TICKS = 60;
    localparam int PH          = 30;
    localparam int OW          = 40;
    localparam int OH          = 10;
    localparam int LEVEL_PTS   = 8;
    localparam int MAX_SPEED   = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       start = 1'b0;
    logic [9:0] xpos = 10'd450, ypos = 10'd250;
    logic [9:0] xpos_obs = 10'd150, ypos_obs = 10'd34;
    logic [9:0] xpos_vobs = 10'd800, ypos_vobs = 10'd514;
    logic [1:0] state;
    logic       move_en;
    logic [3:0] speed;
    logic [1:0] lives;
    logic [9:0] score;
    logic       hit_flash;
    logic       game_over;
    logic [20:0] dut_vec;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: mode 0 idle, 1 play, 2 hit, 3 over.
    int m_mode, m_lives, m_score, m_clean, m_hit_left;
    bit m_coll, m_start_q;

    game_sequencer #(
        .LIVES(LIVES), .HIT_TICKS(HIT_TICKS), .SCORE_TICKS(SCORE_TICKS),
        .PLAYER_HALF(PH), .OBS_HALF_W(OW), .OBS_HALF_H(OH),
        .LEVEL_PTS(LEVEL_PTS), .MAX_SPEED(MAX_SPEED)
    ) dut (
        .clk(clk), .rst(rst), .tick(tick), .start(start),
        .xpos(xpos), .ypos(ypos), .xpos_obs(xpos_obs), .ypos_obs(ypos_obs),
        .xpos_vobs(xpos_vobs), .ypos_vobs(ypos_vobs),
        .state(state), .move_en(move_en), .speed(speed), .lives(lives),
        .score(score), .hit_flash(hit_flash), .game_over(game_over)
    );

    always #5 clk = ~clk;

    assign dut_vec = {state, move_en, speed, lives, score, hit_flash, game_over};

    function automatic int iabs(int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic bit touches(int ox, int oy);
        return (iabs(int'(xpos) - ox) <= PH + OW) && (iabs(int'(ypos) - oy) <= PH + OH);
    endfunction

    function automatic int exp_speed();
`ifdef GAME_SEQ_LEVELUP_EN
        int s = 2 + m_score / LEVEL_PTS;
        return (s > MAX_SPEED) ? MAX_SPEED : s;
`else
        return 2;
`endif
    endfunction

    function automatic logic [20:0] exp_vec();
        return {2'(m_mode), m_mode == 1, 4'(exp_speed()), 2'(m_lives), 10'(m_score),
                m_mode == 2, m_mode == 3};
    endfunction

    task automatic model_edge();
        bit rise = start && !m_start_q;
        if (rst) begin
            m_mode = 0; m_lives = LIVES; m_score = 0; m_clean = 0; m_hit_left = 0;
            m_coll = 0; m_start_q = 0;
            return;
        end
        case (m_mode)
            0: if (rise) m_mode = 1;
            1: if (tick) begin
                if (m_coll) begin
                    m_lives = m_lives - 1;
                    if (m_lives == 0) m_mode = 3;
                    else begin m_mode = 2; m_hit_left = HIT_TICKS; end
                end else begin
                    m_clean = m_clean + 1;
                    if (m_clean % SCORE_TICKS == 0 && m_score < 1023) m_score = m_score + 1;
                end
            end
            2: if (tick) begin
                m_hit_left = m_hit_left - 1;
                if (m_hit_left == 0) m_mode = 1;
            end
            default: if (rise) begin
                m_mode = 1; m_lives = LIVES; m_score = 0; m_clean = 0;
            end
        endcase
        m_coll = touches(int'(xpos_obs), int'(ypos_obs)) || touches(int'(xpos_vobs), int'(ypos_vobs));
        m_start_q = start;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic ticks(int n);
        tick = 1'b1;
        for (int i = 0; i < n; i++) step();
        tick = 1'b0;
    endtask

    task automatic set_far();
        xpos = 10'd450; ypos = 10'd250;
        xpos_obs = 10'd150; ypos_obs = 10'd34;
        xpos_vobs = 10'd800; ypos_vobs = 10'd514;
    endtask

    task automatic press_start();
        start = 1'b1; step();
        start = 1'b0; step();
    endtask

    task automatic test_reset();
        set_far();
        rst = 1'b1; step(); step();
        n_checks++;
        if (dut_vec !== exp_vec()) begin
            n_errors++; $display("FAIL reset_model: got %h expected %h", dut_vec, exp_vec());
        end
        n_checks++;
        if ({state, move_en, speed, lives, score, hit_flash, game_over} !== {2'd0, 1'b0, 4'd2, 2'd3, 10'd0, 1'b0, 1'b0}) begin
            n_errors++; $display("FAIL reset_values: got %h expected state0 lives3 speed2", dut_vec);
        end
        rst = 1'b0; step();
    endtask

    task automatic test_start();
        start = 1'b1; step();
        n_checks++;
        if (state !== 2'd1 || lives !== 2'd3 || score !== 10'd0 || speed !== 4'd2 || move_en !== 1'b1) begin
            n_errors++; $display("FAIL start_play: got %h expected play lives3 score0", dut_vec);
        end
        start = 1'b0; step();
    endtask

    task automatic test_collision_boundary();
        xpos_obs = 10'd521; ypos_obs = 10'd250; step();
        ticks(1);
        n_checks++;
        if (state !== 2'd1 || lives !== 2'd3) begin
            n_errors++; $display("FAIL dx71_nohit: got state %0d lives %0d expected 1 3", state, lives);
        end
        xpos_obs = 10'd520; step();
        ticks(1);
        n_checks++;
        if (state !== 2'd2 || lives !== 2'd2 || hit_flash !== 1'b1 || move_en !== 1'b0) begin
            n_errors++; $display("FAIL dx70_hit: got %h expected hit lives2", dut_vec);
        end
        n_checks++;
        if (dut_vec !== exp_vec()) begin
            n_errors++; $display("FAIL dx70_model: got %h expected %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_hit_recovery();
        ticks(HIT_TICKS - 1);
        n_checks++;
        if (state !== 2'd2) begin
            n_errors++; $display("FAIL hit_29: got state %0d expected 2", state);
        end
        ticks(1);
        n_checks++;
        if (state !== 2'd1 || lives !== 2'd2) begin
            n_errors++; $display("FAIL hit_30: got state %0d lives %0d expected 1 2", state, lives);
        end
        ticks(1);
        n_checks++;
        if (state !== 2'd2 || lives !== 2'd1) begin
            n_errors++; $display("FAIL rehit: got state %0d lives %0d expected 2 1", state, lives);
        end
        set_far(); step();
        ticks(HIT_TICKS);
        n_checks++;
        if (dut_vec !== exp_vec() || state !== 2'd1) begin
            n_errors++; $display("FAIL hit_exit: got %h expected %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_game_over();
        int guard = 0;
        xpos_obs = 10'd450; ypos_obs = 10'd290;
        xpos_vobs = 10'd450; ypos_vobs = 10'd250;
        step();
        while (state !== 2'd3 && guard < 200) begin ticks(1); guard++; end
        n_checks++;
        if (state !== 2'd3 || game_over !== 1'b1 || lives !== 2'd0 || move_en !== 1'b0) begin
            n_errors++; $display("FAIL over_reach: got %h expected over lives0", dut_vec);
        end
        press_start();
        n_checks++;
        if (state !== 2'd1 || lives !== 2'd3 || score !== 10'd0 || game_over !== 1'b0) begin
            n_errors++; $display("FAIL restart: got %h expected play lives3 score0", dut_vec);
        end
        ticks(1);
        n_checks++;
        if (lives !== 2'd2 || state !== 2'd2) begin
            n_errors++; $display("FAIL both_one_life: got lives %0d state %0d expected 2 2", lives, state);
        end
        ticks(HIT_TICKS + 1);
        ticks(HIT_TICKS + 1);
        n_checks++;
        if (dut_vec !== exp_vec() || state !== 2'd3 || lives !== 2'd0) begin
            n_errors++; $display("FAIL three_hits: got %h expected %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_scoring();
        set_far();
        rst = 1'b1; step(); rst = 1'b0; step();
        press_start();
        ticks(2 * SCORE_TICKS);
        n_checks++;
        if (score !== 10'd2 || state !== 2'd1) begin
            n_errors++; $display("FAIL score_120: got score %0d expected 2", score);
        end
        ticks(SCORE_TICKS - 1);
        xpos_obs = 10'd450; ypos_obs = 10'd250; step();
        ticks(1);
        n_checks++;
        if (score !== 10'd2 || lives !== 2'd2 || state !== 2'd2) begin
            n_errors++; $display("FAIL coll_no_score: got score %0d lives %0d expected 2 2", score, lives);
        end
        n_checks++;
        if (dut_vec !== exp_vec()) begin
            n_errors++; $display("FAIL coll_model: got %h expected %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_idle_tick_start();
        set_far();
        rst = 1'b1; step(); rst = 1'b0; step();
        start = 1'b1; tick = 1'b1; step();
        start = 1'b0; tick = 1'b0;
        n_checks++;
        if (state !== 2'd1) begin
            n_errors++; $display("FAIL idle_tick_start: got state %0d expected 1", state);
        end
        ticks(SCORE_TICKS - 1);
        n_checks++;
        if (score !== 10'd0) begin
            n_errors++; $display("FAIL tick_not_counted: got score %0d expected 0", score);
        end
        ticks(1);
        n_checks++;
        if (score !== 10'd1) begin
            n_errors++; $display("FAIL first_point: got score %0d expected 1", score);
        end
    endtask

    task automatic test_reset_mid_hit();
        xpos_obs = 10'd450; ypos_obs = 10'd250; step();
        ticks(3);
        n_checks++;
        if (hit_flash !== 1'b1) begin
            n_errors++; $display("FAIL pre_reset_hit: got hit_flash %0b expected 1", hit_flash);
        end
        rst = 1'b1; tick = 1'b1; start = 1'b1; step();
        rst = 1'b0; tick = 1'b0; start = 1'b0;
        n_checks++;
        if ({state, move_en, speed, lives, score, hit_flash, game_over} !== {2'd0, 1'b0, 4'd2, 2'd3, 10'd0, 1'b0, 1'b0}) begin
            n_errors++; $display("FAIL reset_mid_hit: got %h expected reset values", dut_vec);
        end
        set_far(); step();
    endtask

    task automatic test_saturation();
        set_far();
        rst = 1'b1; step(); rst = 1'b0; step();
        press_start();
        ticks(LEVEL_PTS * SCORE_TICKS);
`ifdef GAME_SEQ_LEVELUP_EN
        n_checks++;
        if (speed !== 4'd3 || score !== 10'd8) begin
            n_errors++; $display("FAIL levelup: got speed %0d score %0d expected 3 8", speed, score);
        end
`else
        n_checks++;
        if (speed !== 4'd2 || score !== 10'd8) begin
            n_errors++; $display("FAIL fixed_speed: got speed %0d score %0d expected 2 8", speed, score);
        end
`endif
        ticks((1023 - LEVEL_PTS) * SCORE_TICKS);
        n_checks++;
        if (score !== 10'd1023) begin
            n_errors++; $display("FAIL score_1023: got score %0d expected 1023", score);
        end
        ticks(2 * SCORE_TICKS + 5);
        n_checks++;
        if (dut_vec !== exp_vec() || score !== 10'd1023) begin
            n_errors++; $display("FAIL score_sat: got %h expected %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_random();
        int px, py;
        rst = 1'b1; step(); rst = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            px = $urandom_range(200, 700);
            py = $urandom_range(100, 400);
            xpos = 10'(px); ypos = 10'(py);
            xpos_obs  = 10'(px + $urandom_range(0, 200) - 100);
            ypos_obs  = 10'(py + $urandom_range(0, 120) - 60);
            xpos_vobs = ($urandom_range(0, 3) == 0) ? 10'(px + $urandom_range(0, 160) - 80) : 10'd900;
            ypos_vobs = 10'(py + $urandom_range(0, 120) - 60);
            tick = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 19) == 0) start = ~start;
            rst = ($urandom_range(0, 399) == 0);
            step();
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                n_errors++; $display("FAIL random_%0d: got %h expected %h", i, dut_vec, exp_vec());
            end
        end
        rst = 1'b0; tick = 1'b0; start = 1'b0;
    endtask

    initial begin
        test_reset();
        test_start();
        test_collision_boundary();
        test_hit_recovery();
        test_game_over();
        test_scoring();
        test_idle_tick_start();
        test_reset_mid_hit();
        test_saturation();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
